// File: rtl/instr_fetch_pkg.sv
// Shared constants and helpers for the fetch stage.
// The OP_HALT opcode and the opcode field live here.
`ifndef OP_HALT
`define OP_HALT 4'hF
`endif

package instr_fetch_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;
  localparam logic [15:0] RESET_PC_DEF = 16'h0000;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;

  function automatic logic [3:0] opcode(
    input logic [15:0] w
  );
    return w[OPC_HI:OPC_LO];
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-to-decode handshake bundle.
// The fetch side is the master and decode is the slave.
interface instr_fetch_if
  import instr_fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              out_valid;
  logic [DATA_W-1:0] out_instr;
  logic [ADDR_W-1:0] out_pc;
  logic              out_ready;

  modport master (
    output out_valid,
    output out_instr,
    output out_pc,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_instr,
    input  out_pc,
    output out_ready
  );

endinterface

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding {pc, instr} pairs.
// It accepts push and pop together when full, and it has a flush input.
module fetch_queue #(
  parameter int W     = 32,
  parameter int DEPTH = 2,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          valid,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;

  logic do_pop;

  assign valid  = (count != '0);
  assign do_pop = pop & valid;
  assign dout   = valid ? mem[rptr] : '0;

  always_ff @(posedge clk) begin
    if (rst | flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push)
        wptr <= wptr + PW'(1);
      if (do_pop)
        rptr <= rptr + PW'(1);
      unique case (1'b1)
        push & ~do_pop: count <= count + CW'(1);
        do_pop & ~push: count <= count - CW'(1);
        default:        count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push & ~rst & ~flush)
      mem[wptr] <= din;
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: holds the PC, drives the ROM port, and queues {pc, instr} for decode.
// Define FETCH_HALT_EN to stop fetching after an OP_HALT word.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int          ADDR_W   = ADDR_W_DEF,
  parameter int          DATA_W   = DATA_W_DEF,
  parameter [ADDR_W-1:0] RESET_PC = RESET_PC_DEF,
  parameter int          QDEPTH   = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_en,
  input  logic [DATA_W-1:0] rom_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  instr_fetch_if.master     dec,
  output logic              halted
);

  localparam int EW = ADDR_W + DATA_W;
  localparam int CW = $clog2(QDEPTH + 1);

  logic [ADDR_W-1:0] pc;
  logic [CW-1:0]     cnt;
  logic              qv;
  logic [EW-1:0]     head;
  logic              pop;
  logic              fetch;

  assign pop   = dec.out_valid & dec.out_ready;
  assign fetch = ~rst & ~redirect_valid & ~halted
               & ((cnt < CW'(QDEPTH)) | pop);

  assign rom_addr = pc;
  assign rom_en   = fetch;

  // Gate on rst so a stale head never shows during reset.
  assign dec.out_valid = qv & ~rst;
  assign dec.out_pc    = dec.out_valid ? head[EW-1 -: ADDR_W] : '0;
  assign dec.out_instr = dec.out_valid ? head[DATA_W-1:0] : '0;

  fetch_queue #(
    .W     (EW),
    .DEPTH (QDEPTH)
  ) u_q (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (fetch),
    .pop   (pop),
    .din   ({pc, rom_data}),
    .dout  (head),
    .valid (qv),
    .count (cnt)
  );

  always_ff @(posedge clk) begin
    if (rst)
      pc <= RESET_PC;
    else if (redirect_valid)
      pc <= redirect_pc;
    else if (fetch)
      pc <= pc + ADDR_W'(1);
  end

`ifdef FETCH_HALT_EN
  always_ff @(posedge clk) begin
    if (rst)
      halted <= 1'b0;
    else if (redirect_valid)
      halted <= 1'b0;
    else if (fetch && opcode(rom_data[15:0]) == `OP_HALT)
      halted <= 1'b1;
  end
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus random traffic.
// Checks run against a queue-based reference model.
module tb_instr_fetch;

  localparam int QD = 2;
`ifdef FETCH_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] rom_addr;
  logic [15:0] rom_data;
  logic [15:0] redirect_pc;
  logic        rom_en;
  logic        redirect_valid;
  logic        halted;
  bit          hlt_mode;

  instr_fetch_if #(.ADDR_W(16), .DATA_W(16)) dif();

  instr_fetch #(
    .ADDR_W   (16),
    .DATA_W   (16),
    .RESET_PC (16'h0000),
    .QDEPTH   (QD)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rom_addr       (rom_addr),
    .rom_en         (rom_en),
    .rom_data       (rom_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec            (dif.master),
    .halted         (halted)
  );

  function automatic logic [15:0] rom_fn(
    input logic [15:0] a,
    input bit          hm
  );
    if (hm && a == 16'h0003)
      return 16'hF000;
    return 16'hA000 + a;
  endfunction

  assign rom_data = rom_fn(rom_addr, hlt_mode);

  int          total;
  int          bad;
  logic [15:0] q[$];
  logic [15:0] mpc;
  bit          mhalt;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    bit          ev;
    bit          ep;
    bit          ef;
    logic [15:0] hp;
    logic [15:0] w;
    @(negedge clk);
    ev = !rst && q.size() > 0;
    hp = ev ? q[0] : 16'h0000;
    ep = ev && dif.out_ready;
    ef = !rst && !redirect_valid && !mhalt
       && (q.size() < QD || ep);
    check("out_valid", 32'(dif.out_valid), 32'(ev));
    check("out_pc", 32'(dif.out_pc), 32'(hp));
    w = ev ? rom_fn(hp, hlt_mode) : 16'h0000;
    check("out_instr", 32'(dif.out_instr), 32'(w));
    check("rom_en", 32'(rom_en), 32'(ef));
    check("rom_addr", 32'(rom_addr), 32'(mpc));
    check("halted", 32'(halted), 32'(mhalt));
    if (rst) begin
      q.delete();
      mpc   = 16'h0000;
      mhalt = 1'b0;
    end else begin
      if (ep)
        void'(q.pop_front());
      if (redirect_valid) begin
        q.delete();
        mpc   = redirect_pc;
        mhalt = 1'b0;
      end else if (ef) begin
        q.push_back(mpc);
        w = rom_fn(mpc, hlt_mode);
        if (HALT_EN && w[15:12] == 4'hF)
          mhalt = 1'b1;
        mpc = mpc + 16'h0001;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++)
      cyc();
  endtask

  task automatic redir(input logic [15:0] t);
    redirect_valid = 1'b1;
    redirect_pc    = t;
    cyc();
    redirect_valid = 1'b0;
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    hlt_mode       = 1'b0;
    dif.out_ready  = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0000;
    @(posedge clk);
    #1;
    mpc   = 16'h0000;
    mhalt = 1'b0;
    run(3);
    rst = 1'b0;
    run(10);

    dif.out_ready = 1'b0;
    run(8);
    dif.out_ready = 1'b1;
    run(6);

    redir(16'h0040);
    run(5);

    redir(16'hFFFF);
    run(5);

    dif.out_ready = 1'b0;
    run(4);
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    dif.out_ready = 1'b1;
    run(5);

    hlt_mode = 1'b1;
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    run(10);
    redir(16'h0010);
    run(5);
    rst = 1'b1;
    run(1);
    hlt_mode = 1'b0;
    rst = 1'b0;

    for (int i = 0; i < 2000; i++) begin
      dif.out_ready  = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0)
                     ? 16'hFFFF : 16'($urandom);
      rst            = ($urandom_range(0, 63) == 0);
      cyc();
    end
    rst            = 1'b0;
    redirect_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
